// File: rtl/cpu_alu_wb_if.sv
// Execute-to-writeback handshake bundle for cpu_alu_wb.
//   ex_* : completed ALU op offered by the execute stage (valid/ready)
//   wb_* : pending writeback entry offered to the register file (valid/ready)
// Modports: master = driver of ex_* and consumer of wb_* (execute side / bench),
//           slave  = the writeback stage itself.
interface cpu_alu_wb_if #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DST_W  = 3
);
   logic              ex_valid;
   logic              ex_ready_c;
   logic [3:0]        ex_opr_select;
   logic [2:0]        ex_func;
   logic [DST_W-1:0]  ex_dst;
   logic              ex_wr;
   logic [DATA_W-1:0] ex_data;

   logic              wb_valid;
   logic              wb_ready;
   logic [DST_W-1:0]  wb_dst;
   logic [DATA_W-1:0] wb_data;
   logic              wb_wr;

   modport master (
      output ex_valid, ex_opr_select, ex_func, ex_dst, ex_wr, ex_data, wb_ready,
      input  ex_ready_c, wb_valid, wb_dst, wb_data, wb_wr
   );

   modport slave (
      input  ex_valid, ex_opr_select, ex_func, ex_dst, ex_wr, ex_data, wb_ready,
      output ex_ready_c, wb_valid, wb_dst, wb_data, wb_wr
   );
endinterface

// File: rtl/cpu_alu_wb.sv
// Execute-to-writeback stage behind the 8008-class ALU.
// One-entry pipeline register with valid/ready handshake, architectural flag
// register (CF/ZF/SF/PF) with per-op-class update masks, and jump/call/return
// condition evaluation.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   bus (slave)           ex_* accept side, wb_* writeback side
//   alu_cf/zf/sf/pf       flag outputs of the ALU for the offered op
//   flush                 discard pending and incoming op
//   flag_cf/zf/sf/pf      architectural flags
//   cond_sel, cond_true   condition select (00 CF,01 ZF,10 SF,11 PF) / sense
//   cond_c                condition met (combinational)
// Optional build macro: CPU_ALU_WB_FLAG_BYPASS_EN -- flags and cond_c reflect
// the masked incoming ALU flags during an accept cycle.
module cpu_alu_wb #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DST_W  = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   cpu_alu_wb_if.slave      bus,
   input  logic             alu_cf,
   input  logic             alu_zf,
   input  logic             alu_sf,
   input  logic             alu_pf,
   input  logic             flush,
   output logic             flag_cf,
   output logic             flag_zf,
   output logic             flag_sf,
   output logic             flag_pf,
   input  logic [1:0]       cond_sel,
   input  logic             cond_true,
   output logic             cond_c
);

   localparam logic [3:0] OP_ALU = 4'b1000;
   localparam logic [3:0] OP_ROT = 4'b0100;
   localparam logic [3:0] OP_INC = 4'b0010;
   localparam logic [3:0] OP_DCR = 4'b0001;
   localparam logic [2:0] FN_CMP = 3'b111;

   logic              wb_valid_q;
   logic [DST_W-1:0]  wb_dst_q;
   logic [DATA_W-1:0] wb_data_q;
   logic              wb_wr_q;
   logic              cf_q, zf_q, sf_q, pf_q;

   logic accept;
   logic eff_wr;
   logic upd_cf;
   logic upd_zsp;
   logic cf_nxt, zf_nxt, sf_nxt, pf_nxt;
   logic [3:0] flags_out;

   // Handshake and op decode
   assign bus.ex_ready_c = (~wb_valid_q | bus.wb_ready) & ~flush;
   assign accept         = bus.ex_valid & bus.ex_ready_c;
   // Compare only sets flags; it never writes a register
   assign eff_wr  = bus.ex_wr & ~((bus.ex_opr_select == OP_ALU) && (bus.ex_func == FN_CMP));
   assign upd_cf  = (bus.ex_opr_select == OP_ALU) || (bus.ex_opr_select == OP_ROT);
   assign upd_zsp = (bus.ex_opr_select == OP_ALU) || (bus.ex_opr_select == OP_INC) ||
                    (bus.ex_opr_select == OP_DCR);

   // Masked next-state flags
   always_comb begin
      cf_nxt = cf_q;
      zf_nxt = zf_q;
      sf_nxt = sf_q;
      pf_nxt = pf_q;
      if (accept && upd_cf) begin
         cf_nxt = alu_cf;
      end
      if (accept && upd_zsp) begin
         zf_nxt = alu_zf;
         sf_nxt = alu_sf;
         pf_nxt = alu_pf;
      end
   end

   // Writeback entry register; flush dominates drain and accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_valid_q <= 1'b0;
         wb_dst_q   <= '0;
         wb_data_q  <= '0;
         wb_wr_q    <= 1'b0;
      end else if (flush) begin
         wb_valid_q <= 1'b0;
      end else if (accept) begin
         wb_valid_q <= 1'b1;
         wb_dst_q   <= bus.ex_dst;
         wb_data_q  <= bus.ex_data;
         wb_wr_q    <= eff_wr;
      end else if (bus.wb_ready) begin
         wb_valid_q <= 1'b0;
      end
   end

   // Architectural flag register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cf_q <= 1'b0;
         zf_q <= 1'b0;
         sf_q <= 1'b0;
         pf_q <= 1'b0;
      end else begin
         cf_q <= cf_nxt;
         zf_q <= zf_nxt;
         sf_q <= sf_nxt;
         pf_q <= pf_nxt;
      end
   end

   assign bus.wb_valid = wb_valid_q;
   assign bus.wb_dst   = wb_dst_q;
   assign bus.wb_data  = wb_data_q;
   assign bus.wb_wr    = wb_wr_q;

`ifdef CPU_ALU_WB_FLAG_BYPASS_EN
   // Zero-latency view: incoming masked flags during an accept cycle
   assign flag_cf = cf_nxt;
   assign flag_zf = zf_nxt;
   assign flag_sf = sf_nxt;
   assign flag_pf = pf_nxt;
`else
   assign flag_cf = cf_q;
   assign flag_zf = zf_q;
   assign flag_sf = sf_q;
   assign flag_pf = pf_q;
`endif

   // Condition: selected flag compared against requested sense
   assign flags_out = {flag_pf, flag_sf, flag_zf, flag_cf};
   assign cond_c    = ~(flags_out[cond_sel] ^ cond_true);

endmodule

// File: tb/tb_cpu_alu_wb.sv
// Directed self-checking bench for cpu_alu_wb.
module tb_cpu_alu_wb;

   logic       clk;
   logic       rst_n;
   logic       alu_cf, alu_zf, alu_sf, alu_pf;
   logic       flush;
   logic       flag_cf, flag_zf, flag_sf, flag_pf;
   logic [1:0] cond_sel;
   logic       cond_true;
   logic       cond_c;

   int n_checks = 0;
   int n_errors = 0;

   cpu_alu_wb_if #(.DATA_W(8), .DST_W(3)) bus ();

   cpu_alu_wb #(.DATA_W(8), .DST_W(3)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .alu_cf   (alu_cf),
      .alu_zf   (alu_zf),
      .alu_sf   (alu_sf),
      .alu_pf   (alu_pf),
      .flush    (flush),
      .flag_cf  (flag_cf),
      .flag_zf  (flag_zf),
      .flag_sf  (flag_sf),
      .flag_pf  (flag_pf),
      .cond_sel (cond_sel),
      .cond_true(cond_true),
      .cond_c   (cond_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic check_flags(input string tag, input logic [3:0] exp_cszp);
      check({tag, ".flags"}, {28'h0, flag_cf, flag_zf, flag_sf, flag_pf}, {28'h0, exp_cszp});
   endtask

   task automatic check_wb(input string tag, input logic v, input logic [2:0] d,
                           input logic [7:0] data, input logic w);
      check({tag, ".wb_valid"}, {31'h0, bus.wb_valid}, {31'h0, v});
      check({tag, ".wb_dst"},   {29'h0, bus.wb_dst},   {29'h0, d});
      check({tag, ".wb_data"},  {24'h0, bus.wb_data},  {24'h0, data});
      check({tag, ".wb_wr"},    {31'h0, bus.wb_wr},    {31'h0, w});
   endtask

   // Present an op: opr, func, dst, wr, data, flags {cf,zf,sf,pf}
   task automatic drive_op(input logic [3:0] opr, input logic [2:0] fn, input logic [2:0] d,
                           input logic w, input logic [7:0] data, input logic [3:0] f);
      bus.ex_valid      = 1'b1;
      bus.ex_opr_select = opr;
      bus.ex_func       = fn;
      bus.ex_dst        = d;
      bus.ex_wr         = w;
      bus.ex_data       = data;
      {alu_cf, alu_zf, alu_sf, alu_pf} = f;
   endtask

   // One accept edge, then withdraw the op so later checks see registered state
   task automatic issue(input logic [3:0] opr, input logic [2:0] fn, input logic [2:0] d,
                        input logic w, input logic [7:0] data, input logic [3:0] f);
      drive_op(opr, fn, d, w, data, f);
      @(posedge clk); #1;
      bus.ex_valid = 1'b0;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      cond_sel = 2'b00;
      cond_true = 1'b0;
      bus.ex_valid = 1'b0;
      bus.ex_opr_select = 4'b0000;
      bus.ex_func = 3'b000;
      bus.ex_dst = 3'b000;
      bus.ex_wr = 1'b0;
      bus.ex_data = 8'h00;
      bus.wb_ready = 1'b1;
      {alu_cf, alu_zf, alu_sf, alu_pf} = 4'b0000;

      repeat (3) @(posedge clk);
      #1;
      check_wb("reset", 1'b0, 3'd0, 8'h00, 1'b0);
      check_flags("reset", 4'b0000);
      check("reset.cond", {31'h0, cond_c}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("reset.ex_ready", {31'h0, bus.ex_ready_c}, 32'd1);

      // ALU op result 00, flags CF=1 ZF=1 SF=0 PF=1
      issue(4'b1000, 3'b000, 3'd0, 1'b1, 8'h00, 4'b1101);
      check_wb("alu", 1'b1, 3'd0, 8'h00, 1'b1);
      check_flags("alu", 4'b1101);
      cond_sel = 2'b01; cond_true = 1'b1; #1;
      check("alu.cond_zf_set", {31'h0, cond_c}, 32'd1);
      cond_sel = 2'b10; #1;
      check("alu.cond_sf_set", {31'h0, cond_c}, 32'd0);
      cond_true = 1'b0; #1;
      check("alu.cond_sf_clr", {31'h0, cond_c}, 32'd1);

      // INC keeps CF
      issue(4'b0010, 3'b000, 3'd1, 1'b1, 8'h80, 4'b0011);
      check_wb("inc", 1'b1, 3'd1, 8'h80, 1'b1);
      check_flags("inc", 4'b1011);

      // Compare never writes, updates all flags
      issue(4'b1000, 3'b111, 3'd2, 1'b1, 8'h05, 4'b1010);
      check_wb("cmp", 1'b1, 3'd2, 8'h05, 1'b0);
      check_flags("cmp", 4'b1010);

      // Rotate touches CF only
      issue(4'b0100, 3'b000, 3'd3, 1'b1, 8'h2A, 4'b0101);
      check_wb("rot", 1'b1, 3'd3, 8'h2A, 1'b1);
      check_flags("rot", 4'b0010);

      // Drain with nothing incoming
      @(posedge clk); #1;
      check("drain.wb_valid", {31'h0, bus.wb_valid}, 32'd0);

      // Unknown op class passes through without flag change
      issue(4'b0011, 3'b000, 3'd7, 1'b1, 8'h33, 4'b1111);
      check_wb("noop", 1'b1, 3'd7, 8'h33, 1'b1);
      check_flags("noop", 4'b0010);

      // Stall: downstream not ready, op held
      bus.wb_ready = 1'b0;
      drive_op(4'b1000, 3'b000, 3'd4, 1'b1, 8'h11, 4'b0001);
      #1;
      check("stall.ex_ready", {31'h0, bus.ex_ready_c}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check_wb($sformatf("stall%0d", i), 1'b1, 3'd7, 8'h33, 1'b1);
         check("stall.ex_ready_hold", {31'h0, bus.ex_ready_c}, 32'd0);
         check_flags($sformatf("stall%0d", i), 4'b0010);
      end
      bus.wb_ready = 1'b1;
      #1;
      check("release.ex_ready", {31'h0, bus.ex_ready_c}, 32'd1);
      @(posedge clk); #1;
      bus.ex_valid = 1'b0;
      #1;
      check_wb("replace", 1'b1, 3'd4, 8'h11, 1'b1);
      check_flags("replace", 4'b0001);

      // Flush with pending entry and incoming op
      bus.wb_ready = 1'b0;
      flush = 1'b1;
      drive_op(4'b1000, 3'b000, 3'd5, 1'b1, 8'h77, 4'b1110);
      #1;
      check("flush.ex_ready", {31'h0, bus.ex_ready_c}, 32'd0);
      check_flags("flush.same", 4'b0001);
      @(posedge clk); #1;
      bus.ex_valid = 1'b0;
      flush = 1'b0;
      bus.wb_ready = 1'b1;
      #1;
      check("flush.wb_valid", {31'h0, bus.wb_valid}, 32'd0);
      check_flags("flush", 4'b0001);

      // Condition latency on an accept cycle (registered CF is 0 here)
      cond_sel = 2'b00; cond_true = 1'b1;
      drive_op(4'b1000, 3'b000, 3'd6, 1'b1, 8'h01, 4'b1000);
      #1;
`ifdef CPU_ALU_WB_FLAG_BYPASS_EN
      check("bypass.cond", {31'h0, cond_c}, 32'd1);
      check("bypass.cf",   {31'h0, flag_cf}, 32'd1);
`else
      check("nobypass.cond", {31'h0, cond_c}, 32'd0);
      check("nobypass.cf",   {31'h0, flag_cf}, 32'd0);
`endif
      @(posedge clk); #1;
      bus.ex_valid = 1'b0;
      #1;
      check("cond.after_edge", {31'h0, cond_c}, 32'd1);
      check_flags("cond.after_edge", 4'b1000);
      check_wb("cond.after_edge", 1'b1, 3'd6, 8'h01, 1'b1);

      // Asynchronous reset drops pending entry mid-cycle
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      check_wb("async_reset", 1'b0, 3'd0, 8'h00, 1'b0);
      check_flags("async_reset", 4'b0000);
      rst_n = 1'b1;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/cpu_alu_wb.md
Name: cpu_alu_wb

Overview:
- Execute-to-writeback stage directly downstream of the 8008-class ALU.
- Captures the ALU result and flags into a one-entry pipeline register with a valid/ready handshake.
- Maintains the architectural flag register (CF, ZF, SF, PF), applying per-operation update masks.
- Evaluates the jump/call/return condition for the sequencer, and presents the pending result to the register-file write port.

Parameters:
- DATA_W, 8, datapath width of ALU result and writeback data.
- DST_W, 3, destination register index width (A=000, B=001, C=010, D=011, E=100, H=101, L=110, M=111).

Ports:
- CLK_I  in  1  clock, rising edge.
- RSTN_I  in  1  asynchronous active-low reset.
- EX_VALID_I  in  1  execute stage presents a completed ALU op.
- EX_READY_O  out  1  stage can accept this cycle.
- EX_OPR_SELECT_I  in  4  one-hot op class: 1000 ALU, 0100 ROT, 0010 INC, 0001 DCR; other codes = no-op.
- EX_FUNC_I  in  3  ALU/ROT function code; 111 under ALU = compare.
- EX_DST_I  in  DST_W  destination index.
- EX_WR_I  in  1  result is to be written to a register.
- ALU_E_I  in  DATA_W  ALU result.
- ALU_CF_I, ALU_ZF_I, ALU_SF_I, ALU_PF_I  in  1 each  ALU flag outputs.
- FLUSH_I  in  1  discard pending and incoming op (branch taken / interrupt).
- WB_VALID_O  out  1  writeback entry valid.
- WB_READY_I  in  1  register file/memory consumes entry.
- WB_DST_O  out  DST_W  writeback destination.
- WB_DATA_O  out  DATA_W  writeback data.
- WB_WR_O  out  1  writeback is a register write.
- FLAG_CF_O, FLAG_ZF_O, FLAG_SF_O, FLAG_PF_O  out  1 each  architectural flags.
- COND_SEL_I  in  2  condition flag: 00 CF, 01 ZF, 10 SF, 11 PF.
- COND_TRUE_I  in  1  1 = test flag set, 0 = test flag clear.
- COND_O  out  1  condition met.

Behaviour:
- Reset (RSTN_I low, asynchronous): WB_VALID_O=0, WB_DST_O=0, WB_DATA_O=0, WB_WR_O=0, all four flags=0. Reset mid-operation drops any pending entry with no writeback.
- EX_READY_O = (~WB_VALID_O | WB_READY_I) & ~FLUSH_I. This is combinational and yields full throughput, 1 op/cycle.
- Accept = EX_VALID_I & EX_READY_O.
  - On accept, the entry registers ALU_E_I, EX_DST_I and the effective write flag; WB_VALID_O=1 the next cycle. Latency is 1 cycle from accept to WB_VALID_O.
- Effective write = EX_WR_I & ~(EX_OPR_SELECT_I==1000 & EX_FUNC_I==111). Compare never writes, regardless of EX_WR_I.
- Entry drain: if WB_VALID_O & WB_READY_I and there is no accept in the same cycle, WB_VALID_O goes to 0. Simultaneous drain and accept: the new entry replaces the old one and WB_VALID_O stays 1.
- Stall: while WB_VALID_O & ~WB_READY_I, the entry outputs hold stable and EX_READY_O=0.
- Flag update masks apply on accept only, registered, visible the next cycle:
  - 1000 (ALU): CF, ZF, SF, PF all updated.
  - 0100 (ROT): CF only; ZF/SF/PF hold.
  - 0010/0001 (INC/DCR): ZF, SF, PF updated; CF holds.
  - any other code: no flag change; entry still passes through.
- FLUSH_I=1: WB_VALID_O cleared on the next edge, no accept, no flag update. FLUSH_I overrides both drain and accept.
- COND_O = ~(flag[COND_SEL_I] ^ COND_TRUE_I). It is combinational from the registered flags.
- Back-to-back flag-setting ops: each accept overwrites only its masked flags. An op accepted in cycle N is visible to COND_O from cycle N+1.

Optional Feature:
- Macro CPU_ALU_WB_FLAG_BYPASS_EN.
- Defined: FLAG_*_O and COND_O combinationally reflect the masked incoming ALU flags during an accept cycle, giving 0-cycle condition latency. The registered flags still update on the edge.
- Undefined: FLAG_*_O and COND_O come from the flag register only, giving 1-cycle latency.

Test Plan:
- Reset, then release, with COND_SEL=00, COND_TRUE=0 -> all outputs 0, COND_O=1, EX_READY_O=1.
- ALU op 1000/000, ALU_E=8'h00, CF=1, ZF=1, SF=0, PF=1, EX_WR=1, DST=000, WB_READY=1 -> next cycle WB_VALID=1, WB_DATA=00, WB_WR=1, flags CF=1 ZF=1 SF=0 PF=1.
- INC 0010 with ALU_E=8'h80, ZF=0, SF=1, PF=1, CF_in=0, prior CF=1 -> CF stays 1, ZF=0, SF=1.
- Compare 1000/111 with EX_WR=1, ALU_E=8'h05 -> WB_WR=0, flags updated; then ROT 0100 with CF=0, ZF=1 -> only CF changes to 0.
- WB_READY=0 for 3 cycles with EX_VALID held -> EX_READY=0, entry stable. Then WB_READY=1 -> drain and accept in the same cycle, WB_VALID stays 1 with new data.
- Entry pending and FLUSH_I=1 with EX_VALID=1 -> next cycle WB_VALID=0 and flags unchanged. With the bypass macro defined, accept with CF=1, COND_SEL=00, COND_TRUE=1 -> COND_O=1 in the same cycle.
